// File: rtl/dfd_cla_pkg.sv
// dfd_cla_pkg
// Shared types and helpers for the CLA debug-signal popcount trigger.
//   cla_popcnt_mode_e : threshold compare mode (EQ / NE / GE / LE), unsigned.
//   popcnt_cnt_w()    : width needed to hold a ones count of a WIDTH-bit bus.
package dfd_cla_pkg;

   typedef enum logic [1:0] {
      CLA_POPCNT_EQ = 2'd0,
      CLA_POPCNT_NE = 2'd1,
      CLA_POPCNT_GE = 2'd2,
      CLA_POPCNT_LE = 2'd3
   } cla_popcnt_mode_e;

   // A count of 'width' ones needs one bit more than log2(width).
   function automatic int popcnt_cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/dfd_cla_debug_signals_popcount_trigger_if.sv
// dfd_cla_debug_signals_popcount_trigger_if
// Bundles the observed bus, per-channel configuration and per-channel results.
//   master : drives debug_signals and ch_* configuration, reads ch_match/ch_count.
//   slave  : the trigger block itself.
// Channel c occupies slice [c*W +: W] of every packed per-channel field.
// There is no handshake: one new bus sample is accepted every clock, no stalls.
interface dfd_cla_debug_signals_popcount_trigger_if #(
   parameter int WIDTH   = 64,
   parameter int NUM_CH  = 4,
   parameter int DWELL_W = 8
);
   localparam int CNT_W = dfd_cla_pkg::popcnt_cnt_w(WIDTH);

   logic [WIDTH-1:0]          debug_signals;
   logic [NUM_CH-1:0]         ch_en;
   logic [NUM_CH*WIDTH-1:0]   ch_mask;
   logic [NUM_CH*CNT_W-1:0]   ch_value;
   logic [NUM_CH*2-1:0]       ch_mode;
   logic [NUM_CH*DWELL_W-1:0] ch_dwell;
   logic [NUM_CH-1:0]         ch_match;
   logic [NUM_CH*CNT_W-1:0]   ch_count;

   modport master (
      output debug_signals, ch_en, ch_mask, ch_value, ch_mode, ch_dwell,
      input  ch_match, ch_count
   );

   modport slave (
      input  debug_signals, ch_en, ch_mask, ch_value, ch_mode, ch_dwell,
      output ch_match, ch_count
   );
endinterface

// File: rtl/dfd_cla_popcount_pipe.sv
// dfd_cla_popcount_pipe
// Two-stage masked popcount for one channel.
//   Stage 1: filtered = debug_signals & mask, popcount per CHUNK_W slice, registered.
//   Stage 2: sum of the chunk partials, registered as count.
// Ports:
//   clock, reset_n (synchronous, active-low)
//   debug_signals [WIDTH]  observed bus
//   mask          [WIDTH]  channel mask (sampled at stage 1)
//   sum           [CNT_W]  combinational sum of the stage-1 partials (stage-2 input)
//   count         [CNT_W]  registered sum
module dfd_cla_popcount_pipe
   import dfd_cla_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int CHUNK_W = 16,
   localparam int CNT_W  = popcnt_cnt_w(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] debug_signals,
   input  logic [WIDTH-1:0] mask,
   output logic [CNT_W-1:0] sum,
   output logic [CNT_W-1:0] count
);
   localparam int NUM_CHUNK = WIDTH / CHUNK_W;
   localparam int PART_W    = popcnt_cnt_w(CHUNK_W);

   logic [WIDTH-1:0]  filtered;
   logic [PART_W-1:0] part_d [NUM_CHUNK];
   logic [PART_W-1:0] part_q [NUM_CHUNK];
   logic [CNT_W-1:0]  count_q;

   assign filtered = debug_signals & mask;

   always_comb begin
      for (int k = 0; k < NUM_CHUNK; k++) begin
         part_d[k] = '0;
         for (int b = 0; b < CHUNK_W; b++) begin
            part_d[k] = part_d[k] + PART_W'(filtered[k*CHUNK_W + b]);
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < NUM_CHUNK; k++) begin
         if (!reset_n) part_q[k] <= '0;
         else          part_q[k] <= part_d[k];
      end
   end

   // CNT_W holds WIDTH exactly, so the sum cannot wrap.
   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM_CHUNK; k++) begin
         sum = sum + CNT_W'(part_q[k]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= sum;
   end

   assign count = count_q;
endmodule

// File: rtl/dfd_cla_debug_signals_popcount_trigger.sv
// dfd_cla_debug_signals_popcount_trigger
// NUM_CH independent popcount triggers on a shared debug bus. Each channel masks
// the bus, counts ones through a two-stage pipe, compares the sum against a
// threshold (EQ/NE/GE/LE, unsigned), then requires the compare to hold for more
// than ch_dwell consecutive cycles before raising ch_match.
// Ports:
//   clock, reset_n (synchronous, active-low)
//   trig : slave side of dfd_cla_debug_signals_popcount_trigger_if
//          (debug_signals, ch_en/mask/value/mode/dwell in; ch_match, ch_count out)
// Latency: bus sample in cycle t -> ch_count in t+2, ch_match in t+3+dwell.
module dfd_cla_debug_signals_popcount_trigger
   import dfd_cla_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int CHUNK_W = 16,
   parameter int NUM_CH  = 4,
   parameter int DWELL_W = 8
) (
   input logic clock,
   input logic reset_n,
   dfd_cla_debug_signals_popcount_trigger_if.slave trig
);
   localparam int CNT_W = popcnt_cnt_w(WIDTH);
   localparam logic [DWELL_W-1:0] RUN_MAX = {DWELL_W{1'b1}};

   logic [NUM_CH-1:0]       match_bits;
   logic [NUM_CH*CNT_W-1:0] count_bits;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0]   sum;
      logic [CNT_W-1:0]   count;
      logic [CNT_W-1:0]   value;
      logic [DWELL_W-1:0] dwell;
      cla_popcnt_mode_e   mode;
      logic               cmp_hit;
      logic               raw_q;
      logic [DWELL_W-1:0] run_q;
      logic [DWELL_W-1:0] run_next;
      logic               match_q;

      dfd_cla_popcount_pipe #(
         .WIDTH   (WIDTH),
         .CHUNK_W (CHUNK_W)
      ) u_pipe (
         .clock         (clock),
         .reset_n       (reset_n),
         .debug_signals (trig.debug_signals),
         .mask          (trig.ch_mask[c*WIDTH +: WIDTH]),
         .sum           (sum),
         .count         (count)
      );

      assign value = trig.ch_value[c*CNT_W +: CNT_W];
      assign dwell = trig.ch_dwell[c*DWELL_W +: DWELL_W];
      assign mode  = cla_popcnt_mode_e'(trig.ch_mode[c*2 +: 2]);

      // Thresholds above WIDTH fall out naturally: EQ/GE never hit, NE/LE always do.
      always_comb begin
         cmp_hit = 1'b0;
         case (mode)
            CLA_POPCNT_EQ: cmp_hit = (sum == value);
            CLA_POPCNT_NE: cmp_hit = (sum != value);
            CLA_POPCNT_GE: cmp_hit = (sum >= value);
            CLA_POPCNT_LE: cmp_hit = (sum <= value);
            default:       cmp_hit = 1'b0;
         endcase
      end

      // Run length saturates at RUN_MAX, so dwell == RUN_MAX can never match.
      always_comb begin
         run_next = '0;
         if (raw_q) begin
            run_next = (run_q == RUN_MAX) ? run_q : run_q + DWELL_W'(1);
         end
      end

      always_ff @(posedge clock) begin
         if (!reset_n) begin
            raw_q   <= 1'b0;
            run_q   <= '0;
            match_q <= 1'b0;
         end else begin
            raw_q <= trig.ch_en[c] & cmp_hit;
            if (!trig.ch_en[c]) begin
               run_q   <= '0;
               match_q <= 1'b0;
            end else begin
               run_q   <= run_next;
               match_q <= raw_q && (run_next > dwell);
            end
         end
      end

      assign match_bits[c]                 = match_q;
      assign count_bits[c*CNT_W +: CNT_W] = count;
   end

   assign trig.ch_match = match_bits;
   assign trig.ch_count = count_bits;
endmodule

// File: tb/tb_dfd_cla_debug_signals_popcount_trigger.sv
// Testbench for dfd_cla_debug_signals_popcount_trigger (WIDTH=64, CHUNK_W=16,
// NUM_CH=4, DWELL_W=8). Directed vectors with hand-computed expectations, then
// a random multi-channel section checked against a cycle-level reference model.
module tb_dfd_cla_debug_signals_popcount_trigger;
   import dfd_cla_pkg::*;

   localparam int W   = 64;
   localparam int NCH = 4;
   localparam int CW  = 7;
   localparam int DW  = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   dfd_cla_debug_signals_popcount_trigger_if #(.WIDTH(W), .NUM_CH(NCH), .DWELL_W(DW)) trig ();

   dfd_cla_debug_signals_popcount_trigger #(
      .WIDTH(W), .CHUNK_W(16), .NUM_CH(NCH), .DWELL_W(DW)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .trig    (trig)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_s1 [NCH];
   int m_cnt [NCH];
   int m_run [NCH];
   bit m_raw [NCH];
   bit m_match [NCH];

   function automatic bit model_cmp(input int s, input int v, input int mode);
      case (mode)
         0: return s == v;
         1: return s != v;
         2: return s >= v;
         default: return s <= v;
      endcase
   endfunction

   task automatic model_update();
      for (int c = 0; c < NCH; c++) begin
         if (!reset_n) begin
            m_s1[c] = 0; m_cnt[c] = 0; m_run[c] = 0; m_raw[c] = 0; m_match[c] = 0;
         end else begin
            bit en;
            int nr;
            en = trig.ch_en[c];
            if (!en) begin
               m_run[c] = 0;
               m_match[c] = 0;
            end else begin
               nr = m_raw[c] ? ((m_run[c] + 1 > 255) ? 255 : m_run[c] + 1) : 0;
               m_match[c] = m_raw[c] && (nr > int'(trig.ch_dwell[c*DW +: DW]));
               m_run[c] = nr;
            end
            m_raw[c] = en && model_cmp(m_s1[c], int'(trig.ch_value[c*CW +: CW]),
                                       int'(trig.ch_mode[c*2 +: 2]));
            m_cnt[c] = m_s1[c];
            m_s1[c] = $countones(trig.debug_signals & trig.ch_mask[c*W +: W]);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_ch(input int c, input logic en, input logic [63:0] mask,
                         input logic [6:0] value, input logic [1:0] mode,
                         input logic [7:0] dwell);
      trig.ch_en[c]             = en;
      trig.ch_mask[c*W +: W]    = mask;
      trig.ch_value[c*CW +: CW] = value;
      trig.ch_mode[c*2 +: 2]    = mode;
      trig.ch_dwell[c*DW +: DW] = dwell;
   endtask

   function automatic logic [6:0] cnt(input int c);
      return trig.ch_count[c*CW +: CW];
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] tr;
      logic [NCH-1:0] exp_m;
      logic [NCH*CW-1:0] exp_c;
      logic any_m;

      trig.debug_signals = '0;
      trig.ch_en = '0;
      trig.ch_mask = '0;
      trig.ch_value = '0;
      trig.ch_mode = '0;
      trig.ch_dwell = '0;
      reset_n = 1'b0;
      settle(3);
      check("reset_match", trig.ch_match, 0);
      check("reset_count", trig.ch_count, 0);
      reset_n = 1'b1;

      // Single-cycle count: 0xFF, EQ 8, dwell 0.
      set_ch(0, 1'b1, '1, 7'd8, CLA_POPCNT_EQ, 8'd0);
      settle(4);
      trig.debug_signals = 64'hFF;
      step();
      trig.debug_signals = 64'h0;
      step();
      check("t1_count_t2", cnt(0), 8);
      check("t1_match_t2", trig.ch_match[0], 0);
      step();
      check("t1_match_t3", trig.ch_match[0], 1);
      check("t1_count_t3", cnt(0), 0);
      step();
      check("t1_match_t4", trig.ch_match[0], 0);

      // Masking across chunk boundaries.
      set_ch(0, 1'b1, 64'h8001_8001_8001_8001, 7'd8, CLA_POPCNT_GE, 8'd0);
      trig.debug_signals = '1;
      settle(4);
      check("t2_count8", cnt(0), 8);
      check("t2_match8", trig.ch_match[0], 1);
      trig.ch_mask[63:0] = 64'h8001_8001_8001_0000;
      settle(2);
      check("t2_count6", cnt(0), 6);
      check("t2_match_hold", trig.ch_match[0], 1);
      step();
      check("t2_match_drop", trig.ch_match[0], 0);

      // Modes and out-of-range threshold.
      set_ch(0, 1'b1, '1, 7'd64, CLA_POPCNT_EQ, 8'd0);
      settle(4);
      check("t3_count64", cnt(0), 64);
      check("t3_eq64", trig.ch_match[0], 1);
      set_ch(0, 1'b1, '1, 7'd64, CLA_POPCNT_NE, 8'd0);
      settle(4);
      check("t3_ne64", trig.ch_match[0], 0);
      set_ch(0, 1'b1, '1, 7'd65, CLA_POPCNT_GE, 8'd0);
      settle(4);
      check("t3_ge65", trig.ch_match[0], 0);
      set_ch(0, 1'b1, '1, 7'd65, CLA_POPCNT_LE, 8'd0);
      settle(4);
      check("t3_le65", trig.ch_match[0], 1);
      set_ch(0, 1'b1, '1, 7'd65, CLA_POPCNT_EQ, 8'd0);
      settle(4);
      check("t3_eq65", trig.ch_match[0], 0);
      trig.debug_signals = '0;
      set_ch(0, 1'b1, '1, 7'd0, CLA_POPCNT_LE, 8'd0);
      settle(4);
      check("t3_le0_count", cnt(0), 0);
      check("t3_le0_match", trig.ch_match[0], 1);

      // Dwell 3: a 3-cycle run never matches, a 6-cycle run matches for 3 cycles.
      set_ch(0, 1'b1, '1, 7'd4, CLA_POPCNT_GE, 8'd3);
      trig.debug_signals = '0;
      settle(4);
      tr = '0;
      for (int k = 0; k < 16; k++) begin
         trig.debug_signals = (k < 3) ? 64'hF : 64'h0;
         step();
         tr[k] = trig.ch_match[0];
      end
      check("t4_dwell3_run3", tr, 16'h0000);
      tr = '0;
      for (int k = 0; k < 16; k++) begin
         trig.debug_signals = (k < 6) ? 64'hF : 64'h0;
         step();
         tr[k] = trig.ch_match[0];
      end
      check("t4_dwell3_run6", tr, 16'h00E0);

      // Dwell 255 disables the channel even for a long run.
      trig.ch_dwell[7:0] = 8'd255;
      trig.debug_signals = 64'hF;
      any_m = 1'b0;
      for (int k = 0; k < 300; k++) begin
         step();
         any_m = any_m | trig.ch_match[0];
      end
      check("t4_dwell255", any_m, 0);

      // One-cycle enable drop during a dwell-5 run restarts the run.
      set_ch(0, 1'b1, '1, 7'd4, CLA_POPCNT_GE, 8'd5);
      trig.debug_signals = '0;
      settle(4);
      tr = '0;
      for (int k = 0; k < 16; k++) begin
         trig.debug_signals = 64'hF;
         trig.ch_en[0] = (k != 3);
         step();
         tr[k] = trig.ch_match[0];
      end
      check("t5_en_drop", tr, 16'hFC00);

      // Reset while matching, then release with the condition already true.
      trig.ch_dwell[7:0] = 8'd0;
      reset_n = 1'b0;
      step();
      check("t5_rst_match", trig.ch_match, 0);
      check("t5_rst_count", trig.ch_count, 0);
      settle(2);
      reset_n = 1'b1;
      tr = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         tr[k] = trig.ch_match[0];
         if (k == 0) check("t5_post_count_r1", cnt(0), 0);
         if (k == 1) check("t5_post_count_r2", cnt(0), 4);
      end
      check("t5_post_match", tr, 16'h000C);

      // Four independent channels under random stimulus.
      set_ch(0, 1'b1, '1,                     7'd32, CLA_POPCNT_EQ, 8'd0);
      set_ch(1, 1'b1, 64'h00FF_00FF_00FF_00FF, 7'd16, CLA_POPCNT_GE, 8'd2);
      set_ch(2, 1'b1, 64'hFFFF_0000_FFFF_0000, 7'd16, CLA_POPCNT_NE, 8'd1);
      set_ch(3, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 7'd12, CLA_POPCNT_LE, 8'd3);
      for (int k = 0; k < 300; k++) begin
         logic [63:0] r;
         r = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) r = r & {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) r = r | {$urandom, $urandom};
         trig.debug_signals = r;
         trig.ch_en[3] = ($urandom_range(0, 15) != 0);
         if (k == 150) trig.ch_value[1*CW +: CW] = 7'd10;
         step();
         for (int c = 0; c < NCH; c++) begin
            exp_m[c] = m_match[c];
            exp_c[c*CW +: CW] = CW'(m_cnt[c]);
         end
         check("rand_match", trig.ch_match, exp_m);
         check("rand_count", trig.ch_count, exp_c);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/dfd_cla_debug_signals_popcount_trigger.md
# dfd_cla_debug_signals_popcount_trigger

Multi-channel, pipelined successor to the single-channel CLA ones-count match. Each of NUM_CH channels masks the shared debug signal bus, counts set bits with a registered adder tree, and compares against a programmable threshold in one of four modes. A per-channel dwell qualifier requires the condition to hold for a programmable number of consecutive cycles. The registered per-channel match bits feed the CLA event/trigger logic.

## Interface
- WIDTH, 64: debug signal bus width; must be a multiple of CHUNK_W.
- CHUNK_W, 16: popcount chunk width for the stage-1 partial sums.
- NUM_CH, 4: number of independent channels.
- DWELL_W, 8: dwell threshold and run counter width.
- CNT_W (localparam) = $clog2(WIDTH)+1.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- debug_signals  in  WIDTH  shared observed bus.
- ch_en  in  NUM_CH  per-channel enable.
- ch_mask  in  NUM_CH*WIDTH  per-channel bit mask; channel c occupies [c*WIDTH +: WIDTH].
- ch_value  in  NUM_CH*CNT_W  compare threshold.
- ch_mode  in  NUM_CH*2  compare mode: 0 EQ, 1 NE, 2 GE, 3 LE.
- ch_dwell  in  NUM_CH*DWELL_W  extra consecutive cycles required.
- ch_match  out  NUM_CH  qualified match, registered.
- ch_count  out  NUM_CH*CNT_W  registered masked ones count, for debug readback.

## Operation
- Stage 1: filtered = debug_signals & mask. Popcount each CHUNK_W slice and register WIDTH/CHUNK_W partials, each $clog2(CHUNK_W)+1 bits wide.
- Stage 2: sum the partials into count_q (CNT_W bits, never overflows). Register raw_q = compare(sum, ch_value, ch_mode).
  - EQ: sum == value.
  - NE: sum != value.
  - GE: sum >= value.
  - LE: sum <= value.
  - All compares are unsigned.
- Stage 3, dwell logic:
  - run_next = raw_q ? min(run_q+1, 2^DWELL_W-1) : 0.
  - match_next = raw_q && (run_next > ch_dwell).
  - Register both. ch_match = match_q.
- ch_dwell = 0 passes raw_q straight through with one cycle of delay.
- ch_dwell = 2^DWELL_W-1 can never match: run saturates one below the required value. This is intentional and serves as a disable-by-dwell.
- ch_en = 0 forces raw_q, run_q and match_q to 0 at their next update. Stage-1 and count pipeline registers still run, so ch_count stays live while disabled.
- Threshold beyond range (ch_value > WIDTH): EQ and GE never match; NE and LE always match.
- Config is sampled by the stage that uses it:
  - mask at stage 1.
  - value and mode at stage 2.
  - dwell at stage 3.
  - Changing config does not flush the pipeline and does not clear run_q.
- All channels are fully independent. The only shared input is debug_signals.

## Timing
- Reset: every pipeline register is cleared. After reset, ch_match = 0, ch_count = 0 and run_q = 0.
- Input sampled at cycle t affects:
  - ch_count at t+2.
  - ch_match at t+3 + ch_dwell (steady condition, dwell not saturating).
- Match deasserts at t+3 after the first cycle t where the condition is false. There is no hysteresis beyond the dwell.
- Reset asserted mid-run clears everything the same cycle it is sampled. There are no stale matches after release: the first valid ch_match arrives 3 cycles after the first post-reset input.
- ch_en is sampled together with the stage it gates:
  - stage 2 for raw_q.
  - stage 3 for run_q and match_q.
  - Re-enable starts a fresh run from 0.
- Throughput: one new input per cycle, no stalls, no handshake.

## Structure
- dfd_cla_pkg gains:
  - cla_popcnt_mode_e, the 2-bit enum EQ/NE/GE/LE.
  - a popcnt_cnt_w(width) function returning $clog2(width)+1.
- Sub-module dfd_cla_popcount_pipe (parameters WIDTH, CHUNK_W):
  - Contents: mask, chunk partials, stage-2 sum.
  - Outputs: registered count.
  - Instantiated once per channel with a generate loop.
- Compare and dwell logic stay in the top module.

## Test plan
All scenarios use WIDTH=64, CHUNK_W=16, NUM_CH=4.
- Single-cycle count check: mask all ones, bus 0x0000_0000_0000_00FF, ch0 EQ value 8, dwell 0 -> ch_count0 = 8 at t+2; ch_match0 pulses for exactly one cycle at t+3.
- Masking and chunk boundaries: bus all ones, mask 0x8001_8001_8001_8001, GE 8 -> count 8, match. Change mask to 0x8001_8001_8001_0000 -> count 6, match drops 3 cycles after the change.
- Modes and range: count 64; EQ 64 matches, NE 64 does not; value 65 -> GE no match, LE match; all-zero bus with LE 0 -> match.
- Dwell: GE 4 with dwell 3. Condition true for 3 cycles -> no match. Condition true for 6 cycles -> match high for cycles 4–6 of the run (offset +3), low 3 cycles after the run ends. Dwell 255 -> never matches.
- Enable and reset mid-run:
  - Drop ch_en for one cycle during a dwell-5 run -> run restarts; match is delayed by a full dwell.
  - Assert reset_n=0 while ch_match=1 -> all outputs 0 the next cycle; first post-reset match no earlier than 3 cycles after release.
- Channel independence: four channels with distinct masks, modes and dwells, under random bus stimulus, against a cycle-accurate reference model -> bit-exact ch_match and ch_count every cycle.
